control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit that replaces hand-driven T-state stimulus. Steps the datapath
//  through fetch (T0-T2) and a per-opcode execute sequence (T3-T7), one state per clock.
//  Drives the encoder one-hot, register-enable one-hot, Gra/Grb/Grc/Rin/Rout/BAout, ALU_Sel,
//  memory read/write, incPC, conIn and outport enable. Sits beside the datapath at CPU top level.
// PARAMETERS
//  NSEL   32  width of enc_input / reg_enable one-hot vectors
//  ALUW   6   width of ALU_Sel
// PORTS
//  clock        in   1     system clock, all state changes on posedge
//  clr          in   1     asynchronous, active-low reset
//  ir           in   32    instruction register contents; opcode = ir[31:27]
//  CONFFOut     in   1     branch condition flag from datapath
//  stop         in   1     level; halt after current instruction completes
//  enc_input    out  NSEL  bus-source one-hot
//  reg_enable   out  NSEL  register-load one-hot
//  ALU_Sel      out  ALUW  ALU operation select
//  read/write   out  1     memory strobes
//  incPC        out  1     PC increment
//  Gra,Grb,Grc  out  1     register-field selects
//  Rin,Rout,BAout out 1    select-and-encode controls
//  conIn        out  1     load CON FF
//  outport1Enable out 1    load output port
//  run          out  1     high except in HALTED
//  illegal      out  1     one-cycle pulse on unknown opcode
// BEHAVIOUR
//  - clr low: state=RST, all outputs 0 (run=0). First posedge after release -> T0.
//  - Outputs are Moore, decoded from registered state + ir. Indices: Zlow 19, PC 20, IR 21,
//    MDR 22, MAR 23, Y 24, C 25, InPort 26 (enc); Z load = reg_enable[19].
//  - Fetch: T0 enc[20],reg[23],incPC. T1 read,reg[22]. T2 enc[22],reg[21]. ir valid from T3.
//  - R-type ADD/SUB/AND/OR: T3 Grb,Rout,reg[24]; T4 Grc,Rout,ALU_Sel=op,reg[19];
//    T5 enc[19],Gra,Rin -> T0.
//  - ADDI/LDI: T3 Grb,BAout,reg[24]; T4 enc[25],ALU_Sel=ADD,reg[19]; T5 enc[19],Gra,Rin -> T0.
//  - LD: T3-T4 as ADDI; T5 enc[19],reg[23]; T6 read,reg[22]; T7 enc[22],Gra,Rin -> T0.
//  - ST: T3-T4 as ADDI; T5 enc[19],reg[23]; T6 Gra,Rout,reg[22] (read=0);
//    T7 write -> T0.
//  - BR: T3 Gra,Rout,conIn; T4 enc[20],reg[24]; T5 enc[25],ALU_Sel=ADD,reg[19];
//    T6 if CONFFOut: enc[19],reg[20] else idle -> T0. CONFFOut sampled in T6 only.
//  - JR: T3 Gra,Rout,reg[20] -> T0.
//  - IN: T3 Gra,Rin,enc[26] -> T0.
//  - OUT: T3 Gra,Rout,outport1Enable -> T0.
//  - NOP: T3 idle -> T0.
//  - HALT: T3 -> HALTED; all outputs 0, run=0; exit only via clr.
//  - Unknown opcode: illegal=1 in T3, otherwise NOP.
//  - stop sampled on the final execute state; if high, next state = HALTED instead of T0.
//  - Exactly one enc_input bit high in any state that drives the bus; never two.
//  - clr mid-instruction aborts immediately; no write/read pulse completes.
// STRUCTURE
//  - Package cpu_ctrl_pkg: opcode constants (LD 00000, LDI 00001, ST 00010, ADD 00011,
//    SUB 00100, AND 00101, OR 00110, ADDI 01100, BR 10010, JR 10100, IN 10110,
//    OUT 10111, NOP 11010, HALT 11011), ALU_Sel codes, bus index constants,
//    state encoding (RST,T0..T7,HALTED).
//  - One sub-module: ctrl_decode (combinational opcode -> instruction class + ALU_Sel).
// TESTING
//  1. Reset: clr=0 for 3 clocks -> all outputs 0, run=0. Release -> T0 shows enc[20],
//     reg[23], incPC.
//  2. ir=ADD R1,R2,R3 -> T3 Grb,Rout,reg[24]; T4 Grc,ALU_Sel=ADD,reg[19];
//     T5 enc[19],Gra,Rin; next T0. 6 clocks total.
//  3. ld R4,0x54(R0) -> T5 reg[23]; T6 read=1; T7 enc[22],Rin; write never high.
//  4. BR with CONFFOut=1 -> T6 enc[19],reg[20]; with CONFFOut=0 -> T6 enc=0, reg=0.
//  5. in R1 / out R1 -> T3 enc[26],Rin,Gra / outport1Enable,Rout,Gra; back to T0 next clock.
//  6. HALT -> run=0 from T3+1, outputs stay 0 for 20 clocks; stop=1 during ADD ->
//     HALTED after T5; clr pulse in T6 of ST -> write never asserted.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, ALU codes, bus indices and
// state encoding.
package cpu_ctrl_pkg;

  localparam int unsigned AluW = 6;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpBr   = 5'b10010;
  localparam logic [4:0] OpJr   = 5'b10100;
  localparam logic [4:0] OpIn   = 5'b10110;
  localparam logic [4:0] OpOut  = 5'b10111;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  localparam logic [AluW-1:0] AluNone = 6'd0;
  localparam logic [AluW-1:0] AluAdd  = 6'd1;
  localparam logic [AluW-1:0] AluSub  = 6'd2;
  localparam logic [AluW-1:0] AluAnd  = 6'd3;
  localparam logic [AluW-1:0] AluOr   = 6'd4;

  localparam int unsigned IdxZlow   = 19;
  localparam int unsigned IdxPc     = 20;
  localparam int unsigned IdxIr     = 21;
  localparam int unsigned IdxMdr    = 22;
  localparam int unsigned IdxMar    = 23;
  localparam int unsigned IdxY      = 24;
  localparam int unsigned IdxC      = 25;
  localparam int unsigned IdxInPort = 26;

  localparam logic [3:0] StRst    = 4'd0;
  localparam logic [3:0] StT0     = 4'd1;
  localparam logic [3:0] StT1     = 4'd2;
  localparam logic [3:0] StT2     = 4'd3;
  localparam logic [3:0] StT3     = 4'd4;
  localparam logic [3:0] StT4     = 4'd5;
  localparam logic [3:0] StT5     = 4'd6;
  localparam logic [3:0] StT6     = 4'd7;
  localparam logic [3:0] StT7     = 4'd8;
  localparam logic [3:0] StHalted = 4'd9;

  typedef enum logic [3:0] {
    ClsAlu, ClsImm, ClsLd, ClsSt, ClsBr, ClsJr, ClsIn, ClsOut, ClsNop, ClsHalt, ClsIll
  } instr_cls_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: instruction class plus the ALU operation for R-type ops.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]      opcode_i,
  output instr_cls_e      cls_o,
  output logic [AluW-1:0] alu_op_o
);

  always_comb begin
    cls_o    = ClsIll;
    alu_op_o = AluNone;
    case (opcode_i)
      OpAdd:        begin cls_o = ClsAlu; alu_op_o = AluAdd; end
      OpSub:        begin cls_o = ClsAlu; alu_op_o = AluSub; end
      OpAnd:        begin cls_o = ClsAlu; alu_op_o = AluAnd; end
      OpOr:         begin cls_o = ClsAlu; alu_op_o = AluOr;  end
      OpAddi, OpLdi: cls_o = ClsImm;
      OpLd:         cls_o = ClsLd;
      OpSt:         cls_o = ClsSt;
      OpBr:         cls_o = ClsBr;
      OpJr:         cls_o = ClsJr;
      OpIn:         cls_o = ClsIn;
      OpOut:        cls_o = ClsOut;
      OpNop:        cls_o = ClsNop;
      OpHalt:       cls_o = ClsHalt;
      default:      cls_o = ClsIll;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, per-opcode execute T3-T7, Moore outputs decoded from
// the registered state and the instruction register.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NSEL = 32,
  parameter int unsigned ALUW = 6
) (
  input  logic            clock,
  input  logic            clr,
  input  logic [31:0]     ir,
  input  logic            CONFFOut,
  input  logic            stop,
  output logic [NSEL-1:0] enc_input,
  output logic [NSEL-1:0] reg_enable,
  output logic [ALUW-1:0] ALU_Sel,
  output logic            read,
  output logic            write,
  output logic            incPC,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            conIn,
  output logic            outport1Enable,
  output logic            run,
  output logic            illegal
);

  logic [3:0]      state_q, state_d;
  logic [3:0]      last_st;
  instr_cls_e      cls;
  logic [AluW-1:0] alu_op;
  logic            unused_ir;

  assign unused_ir = ^ir[26:0];

  ctrl_decode u_decode (
    .opcode_i (ir[31:27]),
    .cls_o    (cls),
    .alu_op_o (alu_op)
  );

  // Final execute state per class; stop is honoured only there.
  always_comb begin
    last_st = StT3;
    case (cls)
      ClsAlu, ClsImm: last_st = StT5;
      ClsLd, ClsSt:   last_st = StT7;
      ClsBr:          last_st = StT6;
      default:        last_st = StT3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StT0, StT1, StT2: state_d = 4'(state_q + 4'd1);
      StT3, StT4, StT5, StT6, StT7: begin
        if (state_q == StT3 && cls == ClsHalt) begin
          state_d = StHalted;
        end else if (state_q == last_st) begin
          state_d = stop ? StHalted : StT0;
        end else begin
          state_d = 4'(state_q + 4'd1);
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StT0;
    endcase
  end

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    enc_input      = '0;
    reg_enable     = '0;
    ALU_Sel        = '0;
    read           = 1'b0;
    write          = 1'b0;
    incPC          = 1'b0;
    Gra            = 1'b0;
    Grb            = 1'b0;
    Grc            = 1'b0;
    Rin            = 1'b0;
    Rout           = 1'b0;
    BAout          = 1'b0;
    conIn          = 1'b0;
    outport1Enable = 1'b0;
    illegal        = 1'b0;
    run            = (state_q >= StT0) && (state_q <= StT7);
    case (state_q)
      StT0: begin
        enc_input[IdxPc]   = 1'b1;
        reg_enable[IdxMar] = 1'b1;
        incPC              = 1'b1;
      end
      StT1: begin
        read               = 1'b1;
        reg_enable[IdxMdr] = 1'b1;
      end
      StT2: begin
        enc_input[IdxMdr] = 1'b1;
        reg_enable[IdxIr] = 1'b1;
      end
      StT3: begin
        case (cls)
          ClsAlu: begin Grb = 1'b1; Rout = 1'b1; reg_enable[IdxY] = 1'b1; end
          ClsImm, ClsLd, ClsSt: begin Grb = 1'b1; BAout = 1'b1; reg_enable[IdxY] = 1'b1; end
          ClsBr:  begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
          ClsJr:  begin Gra = 1'b1; Rout = 1'b1; reg_enable[IdxPc] = 1'b1; end
          ClsIn:  begin Gra = 1'b1; Rin = 1'b1; enc_input[IdxInPort] = 1'b1; end
          ClsOut: begin Gra = 1'b1; Rout = 1'b1; outport1Enable = 1'b1; end
          ClsIll: illegal = 1'b1;
          default: ;
        endcase
      end
      StT4: begin
        case (cls)
          ClsAlu: begin
            Grc = 1'b1; Rout = 1'b1; ALU_Sel = ALUW'(alu_op); reg_enable[IdxZlow] = 1'b1;
          end
          ClsImm, ClsLd, ClsSt: begin
            enc_input[IdxC] = 1'b1; ALU_Sel = ALUW'(AluAdd); reg_enable[IdxZlow] = 1'b1;
          end
          ClsBr: begin enc_input[IdxPc] = 1'b1; reg_enable[IdxY] = 1'b1; end
          default: ;
        endcase
      end
      StT5: begin
        case (cls)
          ClsAlu, ClsImm: begin enc_input[IdxZlow] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsLd, ClsSt:   begin enc_input[IdxZlow] = 1'b1; reg_enable[IdxMar] = 1'b1; end
          ClsBr: begin
            enc_input[IdxC] = 1'b1; ALU_Sel = ALUW'(AluAdd); reg_enable[IdxZlow] = 1'b1;
          end
          default: ;
        endcase
      end
      StT6: begin
        case (cls)
          ClsLd: begin read = 1'b1; reg_enable[IdxMdr] = 1'b1; end
          ClsSt: begin Gra = 1'b1; Rout = 1'b1; reg_enable[IdxMdr] = 1'b1; end
          ClsBr: begin
            if (CONFFOut) begin
              enc_input[IdxZlow] = 1'b1;
              reg_enable[IdxPc]  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      StT7: begin
        case (cls)
          ClsLd: begin enc_input[IdxMdr] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsSt: write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: stimulus queues the expected output vector for each cycle, a monitor on
// the falling edge pops and compares it against the DUT outputs.
module tb_control_sequencer;

  typedef struct packed {
    logic [31:0] enc;
    logic [31:0] rege;
    logic [5:0]  alu;
    logic [12:0] fl;
  } outv_t;

  localparam logic [12:0] RD   = 13'h0001;
  localparam logic [12:0] WR   = 13'h0002;
  localparam logic [12:0] INC  = 13'h0004;
  localparam logic [12:0] GRA  = 13'h0008;
  localparam logic [12:0] GRB  = 13'h0010;
  localparam logic [12:0] GRC  = 13'h0020;
  localparam logic [12:0] RIN  = 13'h0040;
  localparam logic [12:0] ROUT = 13'h0080;
  localparam logic [12:0] BA   = 13'h0100;
  localparam logic [12:0] CON  = 13'h0200;
  localparam logic [12:0] OUTP = 13'h0400;
  localparam logic [12:0] RUN  = 13'h0800;
  localparam logic [12:0] ILL  = 13'h1000;
  localparam outv_t ZERO = '0;

  logic        clock, clr, CONFFOut, stop;
  logic [31:0] ir;
  logic [31:0] enc_input, reg_enable;
  logic [5:0]  ALU_Sel;
  logic read, write, incPC, Gra, Grb, Grc, Rin, Rout, BAout, conIn, outport1Enable, run, illegal;

  outv_t exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  control_sequencer dut (
    .clock          (clock),
    .clr            (clr),
    .ir             (ir),
    .CONFFOut       (CONFFOut),
    .stop           (stop),
    .enc_input      (enc_input),
    .reg_enable     (reg_enable),
    .ALU_Sel        (ALU_Sel),
    .read           (read),
    .write          (write),
    .incPC          (incPC),
    .Gra            (Gra),
    .Grb            (Grb),
    .Grc            (Grc),
    .Rin            (Rin),
    .Rout           (Rout),
    .BAout          (BAout),
    .conIn          (conIn),
    .outport1Enable (outport1Enable),
    .run            (run),
    .illegal        (illegal)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic outv_t mk(input int e, input int r, input logic [5:0] a,
                               input logic [12:0] f);
    outv_t o;
    o = '0;
    if (e >= 0) o.enc[e] = 1'b1;
    if (r >= 0) o.rege[r] = 1'b1;
    o.alu = a;
    o.fl  = f | RUN;
    return o;
  endfunction

  function automatic logic [31:0] instr(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [18:0] low);
    return {op, ra, rb, low};
  endfunction

  task automatic cyc(input outv_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] w);
    ir = w;
    cyc(mk(20, 23, 6'd0, INC), "fetch_t0");
    cyc(mk(-1, 22, 6'd0, RD), "fetch_t1");
    cyc(mk(22, 21, 6'd0, 13'h0), "fetch_t2");
  endtask

  // Monitor: every falling edge with a pending expectation is one comparison.
  initial begin
    outv_t e, act;
    string t;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        act.enc  = enc_input;
        act.rege = reg_enable;
        act.alu  = ALU_Sel;
        act.fl   = {illegal, run, outport1Enable, conIn, BAout, Rout, Rin, Grc, Grb, Gra,
                    incPC, write, read};
        n_checks++;
        if (act === e) begin
          n_pass++;
        end else begin
          $display("FAIL %s @%0t: got enc=%h reg=%h alu=%h fl=%h, expected enc=%h reg=%h alu=%h fl=%h",
                   t, $time, act.enc, act.rege, act.alu, act.fl, e.enc, e.rege, e.alu, e.fl);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b1; ir = '0; CONFFOut = 1'b0; stop = 1'b0;
    #1 clr = 1'b0;
    @(posedge clock); #1;
    repeat (3) cyc(ZERO, "reset_hold");
    clr = 1'b1;
    cyc(ZERO, "reset_release");

    // ADD R1,R2,R3
    fetch(instr(5'b00011, 4'd1, 4'd2, {4'd3, 15'd0}));
    cyc(mk(-1, 24, 6'd0, GRB | ROUT), "add_t3");
    cyc(mk(-1, 19, 6'd1, GRC | ROUT), "add_t4");
    cyc(mk(19, -1, 6'd0, GRA | RIN), "add_t5");
    // SUB
    fetch(instr(5'b00100, 4'd5, 4'd6, {4'd7, 15'd0}));
    cyc(mk(-1, 24, 6'd0, GRB | ROUT), "sub_t3");
    cyc(mk(-1, 19, 6'd2, GRC | ROUT), "sub_t4");
    cyc(mk(19, -1, 6'd0, GRA | RIN), "sub_t5");
    // ADDI
    fetch(instr(5'b01100, 4'd2, 4'd3, 19'h7));
    cyc(mk(-1, 24, 6'd0, GRB | BA), "addi_t3");
    cyc(mk(25, 19, 6'd1, 13'h0), "addi_t4");
    cyc(mk(19, -1, 6'd0, GRA | RIN), "addi_t5");
    // ld R4,0x54(R0)
    fetch(instr(5'b00000, 4'd4, 4'd0, 19'h54));
    cyc(mk(-1, 24, 6'd0, GRB | BA), "ld_t3");
    cyc(mk(25, 19, 6'd1, 13'h0), "ld_t4");
    cyc(mk(19, 23, 6'd0, 13'h0), "ld_t5");
    cyc(mk(-1, 22, 6'd0, RD), "ld_t6");
    cyc(mk(22, -1, 6'd0, GRA | RIN), "ld_t7");
    // st 0x20(R1),R2
    fetch(instr(5'b00010, 4'd2, 4'd1, 19'h20));
    cyc(mk(-1, 24, 6'd0, GRB | BA), "st_t3");
    cyc(mk(25, 19, 6'd1, 13'h0), "st_t4");
    cyc(mk(19, 23, 6'd0, 13'h0), "st_t5");
    cyc(mk(-1, 22, 6'd0, GRA | ROUT), "st_t6");
    cyc(mk(-1, -1, 6'd0, WR), "st_t7");
    // BR taken
    CONFFOut = 1'b1;
    fetch(instr(5'b10010, 4'd3, 4'd1, 19'h10));
    cyc(mk(-1, -1, 6'd0, GRA | ROUT | CON), "brt_t3");
    cyc(mk(20, 24, 6'd0, 13'h0), "brt_t4");
    cyc(mk(25, 19, 6'd1, 13'h0), "brt_t5");
    cyc(mk(19, 20, 6'd0, 13'h0), "brt_t6");
    // BR not taken: flag high until T6 must not matter
    fetch(instr(5'b10010, 4'd3, 4'd2, 19'h10));
    cyc(mk(-1, -1, 6'd0, GRA | ROUT | CON), "brn_t3");
    cyc(mk(20, 24, 6'd0, 13'h0), "brn_t4");
    cyc(mk(25, 19, 6'd1, 13'h0), "brn_t5");
    CONFFOut = 1'b0;
    cyc(mk(-1, -1, 6'd0, 13'h0), "brn_t6");
    // JR, IN, OUT, NOP, illegal
    fetch(instr(5'b10100, 4'd6, 4'd0, 19'h0));
    cyc(mk(-1, 20, 6'd0, GRA | ROUT), "jr_t3");
    fetch(instr(5'b10110, 4'd1, 4'd0, 19'h0));
    cyc(mk(26, -1, 6'd0, GRA | RIN), "in_t3");
    fetch(instr(5'b10111, 4'd1, 4'd0, 19'h0));
    cyc(mk(-1, -1, 6'd0, GRA | ROUT | OUTP), "out_t3");
    fetch(instr(5'b11010, 4'd0, 4'd0, 19'h0));
    cyc(mk(-1, -1, 6'd0, 13'h0), "nop_t3");
    fetch(instr(5'b11111, 4'd0, 4'd0, 19'h0));
    cyc(mk(-1, -1, 6'd0, ILL), "ill_t3");
    // stop during ADD halts after T5
    fetch(instr(5'b00011, 4'd1, 4'd2, {4'd3, 15'd0}));
    cyc(mk(-1, 24, 6'd0, GRB | ROUT), "stop_t3");
    cyc(mk(-1, 19, 6'd1, GRC | ROUT), "stop_t4");
    stop = 1'b1;
    cyc(mk(19, -1, 6'd0, GRA | RIN), "stop_t5");
    stop = 1'b0;
    repeat (2) cyc(ZERO, "stop_halted");
    clr = 1'b0;
    cyc(ZERO, "stop_clr");
    clr = 1'b1;
    cyc(ZERO, "stop_release");
    // clr in T6 of ST aborts before the write
    fetch(instr(5'b00010, 4'd2, 4'd1, 19'h20));
    cyc(mk(-1, 24, 6'd0, GRB | BA), "abort_t3");
    cyc(mk(25, 19, 6'd1, 13'h0), "abort_t4");
    cyc(mk(19, 23, 6'd0, 13'h0), "abort_t5");
    clr = 1'b0;
    cyc(ZERO, "abort_t6");
    cyc(ZERO, "abort_hold");
    clr = 1'b1;
    cyc(ZERO, "abort_release");
    // HALT
    fetch(instr(5'b11011, 4'd0, 4'd0, 19'h0));
    cyc(mk(-1, -1, 6'd0, 13'h0), "halt_t3");
    repeat (20) cyc(ZERO, "halted");

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
